reg_mem_mp: RTL and testbench
=============================

Name: reg_mem_mp

Overview:
Parametrised multi-read-port register memory. Successor to the single-port reg_mem.
- One masked write port, NUM_RD independent registered read ports.
- Built-in init/clear sequencer walks every address after reset or on request, with a busy flag.
- Used as a scratch store/register file; software-style clear without a reset pulse.

Parameters:
DATA_WIDTH, 8, bits per word
ADDR_BITS, 5, address width; depth DEPTH = 2**ADDR_BITS
NUM_RD, 2, number of read ports (>=1)
INIT_VAL, 0, value written to every word by init/clear (DATA_WIDTH bits)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_BITS  write address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH  per-bit write enable; 1 = bit updated
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*ADDR_BITS  port p address at [p*ADDR_BITS +: ADDR_BITS]
rd_data  out  NUM_RD*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH]
rd_valid  out  NUM_RD  port p rd_data updated this cycle
clr_req  in  1  request full clear to INIT_VAL
busy  out  1  sequencer active; port requests ignored

Behaviour:
- Reset (rst_n=0, async): rd_data=0, rd_valid=0, busy=1, FSM=INIT, sweep counter=0. Array contents are not reset directly; INIT writes them.
- FSM states:
  - INIT: entered from reset; writes INIT_VAL to addr=counter each cycle; counter+1.
  - IDLE: normal operation.
  - CLEAR: same sweep as INIT.
- Transitions:
  - INIT/CLEAR -> IDLE after the write at counter=DEPTH-1; counter wraps to 0.
  - IDLE -> CLEAR on clr_req=1; counter=0.
  - Sweep takes exactly DEPTH cycles. busy=1 in INIT/CLEAR, 0 in IDLE; busy is registered state.
  - Reset mid-sweep restarts INIT from address 0.
- Write (IDLE only):
  - mem[wr_addr] <= (mem & ~wr_mask) | (wr_data & wr_mask).
  - wr_mask=0 leaves the word unchanged.
- Read (IDLE only), per port p:
  - rd_en[p]=1 at edge N gives rd_data[p]=mem[rd_addr[p]] and rd_valid[p]=1 after edge N.
  - Latency 1 cycle.
  - rd_en[p]=0 gives rd_valid[p]=0; rd_data[p] holds its last value.
- Write-first bypass: same-cycle read and write to the same address returns the merged (post-mask) new value. Applies independently on every port.
- Ports may read the same address simultaneously; all return identical data.
- While busy=1: wr_en, rd_en and clr_req are ignored and rd_valid=0. Nothing is queued.
- clr_req and wr_en in the same IDLE cycle: the write commits that cycle, CLEAR starts next cycle, and the word ends at INIT_VAL.
- Address arithmetic is unsigned and modulo DEPTH; no out-of-range case exists.

Decomposition:
- Package reg_mem_pkg holds:
  - state enum {INIT, IDLE, CLEAR}, 2-bit encoding
  - localparam function for DEPTH
  - default-width constants
- One sub-module, reg_mem_sweep, owns the FSM and counter.
  - Outputs: busy, sweep_we, sweep_addr.
  - The top level muxes the sweep write over the user write port.

Test Plan:
1. Reset, then hold idle -> busy=1 for exactly 32 cycles, then 0. Read all addresses on port 0 -> all 0, rd_valid pulses 1 cycle after each rd_en.
2. Write i+10 to address i for i=0..31 (mask 8'hFF). Read addr i on port 0 and addr 31-i on port 1 in the same cycle -> port0=i+10, port1=41-i.
3. Masked write: addr 5 holds 8'h0F; write data 8'hF0, mask 8'h3C -> read 8'h33.
4. Bypass: write 8'hA5 to addr 7 while both ports read addr 7 -> both rd_data=8'hA5 next cycle.
5. In IDLE assert clr_req with a write 8'h55 to addr 3 -> busy high 32 cycles. wr_en/rd_en pulsed mid-clear give rd_valid=0. Afterwards addr 3 and addr 20 read INIT_VAL.
6. Drop rst_n during cycle 10 of CLEAR -> busy stays 1, rd_data=0 immediately, a fresh 32-cycle INIT, then all words read INIT_VAL.

Source files
------------

// File: rtl/reg_mem_pkg.sv
// Shared types and sizing helpers for the multi-read-port register memory.
// Imported by the sweep sequencer and the top level.
package reg_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;
  localparam int DEF_NUM_RD     = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic int depth_of(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/reg_mem_mp_if.sv
// Bus bundle for reg_mem_mp: one masked write port, NUM_RD read ports, clear request and busy.
// The master side drives requests; the slave side is the memory.
interface reg_mem_mp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int NUM_RD     = 2
);
  logic                         wr_en;
  logic [ADDR_BITS-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [DATA_WIDTH-1:0]        wr_mask;
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*ADDR_BITS-1:0]  rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_valid;
  logic                         clr_req;
  logic                         busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/reg_mem_sweep.sv
// Init/clear sequencer: walks every address once after reset or on clr_req,
// holding busy high for exactly DEPTH cycles.
module reg_mem_sweep
  import reg_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 sweep_we,
  output logic [ADDR_BITS-1:0] sweep_addr
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(depth_of(ADDR_BITS) - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
      busy       <= 1'b1;
    end else begin
      case (state)
        ST_INIT, ST_CLEAR: begin
          // Counter wraps to 0 naturally on the last write, ready for the next sweep.
          sweep_addr <= sweep_addr + ADDR_BITS'(1);
          if (sweep_addr == LAST_ADDR) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state      <= ST_CLEAR;
            busy       <= 1'b1;
            sweep_addr <= '0;
          end
        end
        default: begin
          state      <= ST_INIT;
          busy       <= 1'b1;
          sweep_addr <= '0;
        end
      endcase
    end
  end

  assign sweep_we = busy;

endmodule

// File: rtl/reg_mem_mp.sv
// Multi-read-port register memory with masked write, write-first bypass per port,
// and a built-in init/clear sweep that locks out the user ports while running.
module reg_mem_mp
  import reg_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_BITS  = DEF_ADDR_BITS,
  parameter int                    NUM_RD     = DEF_NUM_RD,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic         clk,
  input logic         rst_n,
  reg_mem_mp_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_BITS);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  sweep_we;
  logic [ADDR_BITS-1:0]  sweep_addr;
  logic                  wr_go;
  logic                  clr_go;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_go     = bus.wr_en & ~busy;
  assign clr_go    = bus.clr_req & ~busy;
  assign wr_merged = (mem[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
  assign bus.busy  = busy;

  reg_mem_sweep #(
    .ADDR_BITS (ADDR_BITS)
  ) u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_go),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // The sweep owns the write port whenever busy; user writes are simply dropped then.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VAL;
    end else if (wr_go) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_BITS-1:0]  rd_addr_p;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign rd_addr_p = bus.rd_addr[p*ADDR_BITS +: ADDR_BITS];

    // Write-first: a same-cycle write to this address returns the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (!busy && bus.rd_en[p]) begin
        valid_q <= 1'b1;
        data_q  <= (wr_go && (bus.wr_addr == rd_addr_p)) ? wr_merged : mem[rd_addr_p];
      end else begin
        valid_q <= 1'b0;
      end
    end

    assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign bus.rd_valid[p]                         = valid_q;
  end

endmodule

// File: tb/tb_reg_mem_mp.sv
// Self-checking bench for reg_mem_mp: a cycle-level memory model compared every cycle,
// plus directed vectors with literal expectations.
module tb_reg_mem_mp;

  localparam int         DW    = 8;
  localparam int         AW    = 5;
  localparam int         NR    = 2;
  localparam int         DEPTH = 32;
  localparam logic [7:0] INIT  = 8'h00;

  logic clk;
  logic rst_n;

  reg_mem_mp_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .NUM_RD(NR)) bus ();

  reg_mem_mp #(
    .DATA_WIDTH (DW),
    .ADDR_BITS  (AW),
    .NUM_RD     (NR),
    .INIT_VAL   (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mem_m [DEPTH];
  int         sweep_left;
  logic [7:0] exp_data [NR];
  logic       exp_valid [NR];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: memory is a plain array; a sweep is a countdown that wipes the array and mutes the ports.
  task automatic modelStep();
    logic [4:0] ra;
    logic [7:0] merged;
    if (!rst_n) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
      for (int p = 0; p < NR; p++) begin
        exp_data[p]  = 8'h00;
        exp_valid[p] = 1'b0;
      end
    end else if (sweep_left > 0) begin
      sweep_left = sweep_left - 1;
      for (int p = 0; p < NR; p++) exp_valid[p] = 1'b0;
    end else begin
      merged = (mem_m[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
      for (int p = 0; p < NR; p++) begin
        ra = bus.rd_addr[p*AW +: AW];
        exp_valid[p] = bus.rd_en[p];
        if (bus.rd_en[p]) exp_data[p] = (bus.wr_en && bus.wr_addr == ra) ? merged : mem_m[ra];
      end
      if (bus.wr_en) mem_m[bus.wr_addr] = merged;
      if (bus.clr_req) begin
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      compared = compared + 1;
      if (bus.busy !== (sweep_left > 0)) begin
        mismatched = mismatched + 1;
        $display("[TB] FAIL model_busy t=%0t: got %b expected %b", $time, bus.busy, sweep_left > 0);
      end
      for (int p = 0; p < NR; p++) begin
        compared = compared + 2;
        if (bus.rd_valid[p] !== exp_valid[p]) begin
          mismatched = mismatched + 1;
          $display("[TB] FAIL model_valid%0d t=%0t: got %b expected %b", p, $time, bus.rd_valid[p], exp_valid[p]);
        end
        if (bus.rd_data[p*DW +: DW] !== exp_data[p]) begin
          mismatched = mismatched + 1;
          $display("[TB] FAIL model_data%0d t=%0t: got %0h expected %0h", p, $time, bus.rd_data[p*DW +: DW], exp_data[p]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared = compared + 1;
    if (act !== expv) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drives one sampled clock edge worth of inputs, then returns them to idle.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                               input logic [7:0] wm, input logic [1:0] re,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic clr);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_mask = wm;
    bus.rd_en   = re;
    bus.rd_addr = {ra1, ra0};
    bus.clr_req = clr;
    @(posedge clk);
    #2;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic sweepCount(input int poke_at, output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n = n + 1;
      if (n == poke_at) begin
        applyStimulus(1'b1, 5'd20, 8'h99, 8'hFF, 2'b11, 5'd20, 5'd20, 1'b1);
        checkOutput("busy_rd_valid", 32'(bus.rd_valid), 32'd0);
      end else begin
        applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
      end
    end
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.clr_req = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_busy", 32'(bus.busy), 32'd1);
    checkOutput("reset_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("reset_data", 32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    sweepCount(0, n);
    checkOutput("init_len", 32'(n), 32'd32);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b01, 5'(i), 5'd0, 1'b0);
      checkOutput("init_read_valid", 32'(bus.rd_valid[0]), 32'd1);
      checkOutput("init_read_data", 32'(bus.rd_data[7:0]), 32'(INIT));
    end
    applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
    checkOutput("valid_pulse_end", 32'(bus.rd_valid), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 5'(i), 8'(i + 10), 8'hFF, 2'b00, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b11, 5'(i), 5'(31 - i), 1'b0);
      checkOutput("dual_p0", 32'(bus.rd_data[7:0]), 32'(i + 10));
      checkOutput("dual_p1", 32'(bus.rd_data[15:8]), 32'(41 - i));
    end

    applyStimulus(1'b1, 5'd5, 8'h0F, 8'hFF, 2'b00, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd5, 8'hF0, 8'h3C, 2'b00, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd5, 8'hFF, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b01, 5'd5, 5'd0, 1'b0);
    checkOutput("masked_write", 32'(bus.rd_data[7:0]), 32'h33);

    applyStimulus(1'b1, 5'd7, 8'hA5, 8'hFF, 2'b11, 5'd7, 5'd7, 1'b0);
    checkOutput("bypass_p0", 32'(bus.rd_data[7:0]), 32'hA5);
    checkOutput("bypass_p1", 32'(bus.rd_data[15:8]), 32'hA5);

    applyStimulus(1'b1, 5'd3, 8'h55, 8'hFF, 2'b00, 5'd0, 5'd0, 1'b1);
    checkOutput("clear_busy", 32'(bus.busy), 32'd1);
    sweepCount(10, n);
    checkOutput("clear_len", 32'(n), 32'd32);
    applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b11, 5'd3, 5'd20, 1'b0);
    checkOutput("clear_addr3", 32'(bus.rd_data[7:0]), 32'(INIT));
    checkOutput("clear_addr20", 32'(bus.rd_data[15:8]), 32'(INIT));

    applyStimulus(1'b1, 5'd1, 8'h77, 8'hFF, 2'b00, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b11, 5'd1, 5'd1, 1'b0);
    checkOutput("pre_reset_data", 32'(bus.rd_data), 32'h7777);
    applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 1'b1);
    repeat (9) applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 1'b0);
    checkOutput("mid_clear_hold", 32'(bus.rd_data), 32'h7777);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(bus.rd_data), 32'd0);
    checkOutput("async_rst_busy", 32'(bus.busy), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    sweepCount(0, n);
    checkOutput("reinit_len", 32'(n), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 5'd0, 8'h00, 8'h00, 2'b11, 5'(i), 5'(31 - i), 1'b0);
      checkOutput("reinit_p0", 32'(bus.rd_data[7:0]), 32'(INIT));
      checkOutput("reinit_p1", 32'(bus.rd_data[15:8]), 32'(INIT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
